// File: rtl/dffneg_pipe_if.sv
// Bus bundle for dffneg_pipe: advance/flush controls, input word with valid,
// last-stage output with valid, and occupancy. Scan pins exist only when
// DFFNEG_PIPE_SCAN_EN is defined.
interface dffneg_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int OW = $clog2(DEPTH + 1);

    logic             EN;
    logic             CLR;
    logic [WIDTH-1:0] D;
    logic             DV;
    logic [WIDTH-1:0] Q;
    logic             QV;
    logic [OW-1:0]    OCC;
`ifdef DFFNEG_PIPE_SCAN_EN
    logic             SE;
    logic             SI;
    logic             SO;

    modport master (output EN, CLR, D, DV, SE, SI, input Q, QV, OCC, SO);
    modport slave  (input EN, CLR, D, DV, SE, SI, output Q, QV, OCC, SO);
`else
    modport master (output EN, CLR, D, DV, input Q, QV, OCC);
    modport slave  (input EN, CLR, D, DV, output Q, QV, OCC);
`endif
endinterface

// File: rtl/dffneg_pipe.sv
// Falling-edge register pipeline with per-stage valid bits, stall, flush and
// occupancy count. Optional scan chain through all state bits when
// DFFNEG_PIPE_SCAN_EN is defined (chain order: SI -> vld[0] -> data[0][0..W-1]
// -> vld[1] -> ... -> data[DEPTH-1][WIDTH-1] -> SO).
module dffneg_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic         CLK,
    input  logic         R,
    dffneg_pipe_if.slave bus
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [OW-1:0]    occ_sum;

`ifdef DFFNEG_PIPE_SCAN_EN
    localparam int CHAIN = DEPTH * (WIDTH + 1);

    logic [CHAIN-1:0] chain_cur;
    logic [CHAIN-1:0] chain_nxt;

    // Flatten the state into chain order so a scan shift is a plain shift.
    always_comb begin
        chain_cur = '0;
        for (int i = 0; i < DEPTH; i++) begin
            chain_cur[i*(WIDTH+1)] = vld[i];
            for (int b = 0; b < WIDTH; b++) begin
                chain_cur[i*(WIDTH+1)+1+b] = data[i][b];
            end
        end
    end

    assign chain_nxt = {chain_cur[CHAIN-2:0], bus.SI};
    assign bus.SO    = data[DEPTH-1][WIDTH-1];
`endif

    // Stage registers: reset, then scan (if built), flush, advance, else hold.
    always_ff @(negedge CLK or negedge R) begin
        if (!R) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= RESET_VAL;
            end
            vld <= '0;
        end
`ifdef DFFNEG_PIPE_SCAN_EN
        else if (bus.SE) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld[i] <= chain_nxt[i*(WIDTH+1)];
                for (int b = 0; b < WIDTH; b++) begin
                    data[i][b] <= chain_nxt[i*(WIDTH+1)+1+b];
                end
            end
        end
`endif
        else if (bus.CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= RESET_VAL;
            end
            vld <= '0;
        end else if (bus.EN) begin
            data[0] <= bus.D;
            vld[0]  <= bus.DV;
            for (int i = 1; i < DEPTH; i++) begin
                data[i] <= data[i-1];
                vld[i]  <= vld[i-1];
            end
        end
    end

    // Occupancy is the popcount of the valid bits.
    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OW'(vld[i]);
        end
    end

    assign bus.Q   = data[DEPTH-1];
    assign bus.QV  = vld[DEPTH-1];
    assign bus.OCC = occ_sum;
endmodule

// File: tb/tb_dffneg_pipe.sv
// Self-checking bench for dffneg_pipe (default build, WIDTH=8, DEPTH=4).
module tb_dffneg_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam logic [WIDTH-1:0] RV = 8'h00;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             v;
    } entry_t;

    logic CLK;
    logic R;
    int   total;
    int   bad;
    entry_t mq[$];

    dffneg_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dffneg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
        .CLK (CLK),
        .R   (R),
        .bus (bus)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        entry_t e;
        e.d = RV;
        e.v = 1'b0;
        mq.delete();
        for (int i = 0; i < DEPTH; i++) mq.push_back(e);
    endfunction

    function automatic int model_occ();
        int n = 0;
        foreach (mq[i]) if (mq[i].v) n++;
        return n;
    endfunction

    always @(negedge R) model_clear();

    // Reference model: youngest entry at the front, output word at the back.
    always @(negedge CLK) begin
        entry_t e;
        if (R) begin
            if (bus.CLR) begin
                model_clear();
            end else if (bus.EN) begin
                e.d = bus.D;
                e.v = bus.DV;
                mq.push_front(e);
                void'(mq.pop_back());
            end
        end
        #1;
        check("q",   32'(bus.Q),   32'(mq[DEPTH-1].d));
        check("qv",  32'(bus.QV),  32'(mq[DEPTH-1].v));
        check("occ", 32'(bus.OCC), 32'(model_occ()));
    end

    // Inputs wiggle with junk just after the rising edge, then settle well before the falling edge.
    task automatic step(input logic en, input logic clr, input logic [WIDTH-1:0] d, input logic dv);
        @(posedge CLK);
        #1;
        bus.EN  = ~en;
        bus.CLR = 1'b0;
        bus.D   = ~d;
        bus.DV  = ~dv;
        #1;
        bus.EN  = en;
        bus.CLR = clr;
        bus.D   = d;
        bus.DV  = dv;
        @(negedge CLK);
        #2;
    endtask

    initial begin
        logic [2:0] occ_exp [6];
        total = 0;
        bad   = 0;
        model_clear();
        R       = 1'b0;
        bus.EN  = 1'b0;
        bus.CLR = 1'b0;
        bus.D   = '0;
        bus.DV  = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2;
        check("rst_q",   32'(bus.Q),   32'h00);
        check("rst_qv",  32'(bus.QV),  32'h0);
        check("rst_occ", 32'(bus.OCC), 32'h0);
        @(posedge CLK);
        #1 R = 1'b1;

        // Fill/drain.
        occ_exp[0] = 3'd1; occ_exp[1] = 3'd2; occ_exp[2] = 3'd3;
        occ_exp[3] = 3'd4; occ_exp[4] = 3'd4; occ_exp[5] = 3'd4;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 8'hA1 + 8'(i), 1'b1);
            check("fill_occ", 32'(bus.OCC), 32'(occ_exp[i]));
            if (i == 2) check("fill_qv3", 32'(bus.QV), 32'h0);
            if (i == 3) begin
                check("fill_q4",  32'(bus.Q),  32'hA1);
                check("fill_qv4", 32'(bus.QV), 32'h1);
            end
            if (i == 5) check("fill_q6", 32'(bus.Q), 32'hA3);
        end

        // Flush has priority over advance.
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        check("flush_occ", 32'(bus.OCC), 32'h0);
        check("flush_qv",  32'(bus.QV),  32'h0);
        check("flush_q",   32'(bus.Q),   32'h00);

        // Stall with a bubble.
        step(1'b1, 1'b0, 8'h5A, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'(i + 7), 1'b1);
            check("stall_occ", 32'(bus.OCC), 32'h1);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("stall_qv_early", 32'(bus.QV), 32'h0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("stall_q",  32'(bus.Q),  32'h5A);
        check("stall_qv", 32'(bus.QV), 32'h1);

        // Asynchronous reset mid-stream.
        step(1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b1);
        step(1'b1, 1'b0, 8'h33, 1'b1);
        check("pre_rst_occ", 32'(bus.OCC), 32'h3);
        @(posedge CLK);
        #1 R = 1'b0;
        #1;
        check("arst_q",   32'(bus.Q),   32'h00);
        check("arst_qv",  32'(bus.QV),  32'h0);
        check("arst_occ", 32'(bus.OCC), 32'h0);
        #1 R = 1'b1;
        @(negedge CLK);
        #2;

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0,
                 8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
